// File: rtl/bcd_conversion_sequencer_pkg.sv
// Shared constants and the digit-adjust rule for the sequential binary-to-BCD converter.
// The FSM encoding and the add-3 rule live here so the top and digit slice agree.
package bcd_conversion_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // The sum wraps at 4 bits: out-of-range digits never carry into a neighbour.
    function automatic logic [BCD_DIGIT_W-1:0] bcd_adjust(input logic [BCD_DIGIT_W-1:0] digit);
        logic [BCD_DIGIT_W-1:0] result;
        result = digit;
        if (digit >= BCD_ADJ_THRESH) begin
            result = digit + BCD_ADJ_ADD;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_conversion_sequencer_if.sv
// Request/result bundle between a binary source and the BCD converter.
interface bcd_conversion_sequencer_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/bcd_conversion_sequencer_digit_adjust.sv
// One BCD digit of the double-dabble pre-shift correction: values of 5 or more get +3.
module bcd_digit_adjust
    import bcd_conversion_sequencer_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = bcd_adjust(digit_in);

endmodule

// File: rtl/bcd_conversion_sequencer.sv
// Sequential double-dabble converter: one adjust+shift per clock, one binary bit per step.
// bcd_out is a separate holding register so scratch digits are never visible outside.
module bcd_conversion_sequencer
    import bcd_conversion_sequencer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    bcd_conversion_sequencer_if.slave bus
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_reg,   state_next;
    logic [WIDTH-1:0]   bin_reg,     bin_next;
    logic [BCD_W-1:0]   scratch_reg, scratch_next;
    logic [BCD_W-1:0]   bcd_reg,     bcd_next;
    logic [CNT_W-1:0]   count_reg,   count_next;
    logic [BCD_W-1:0]   adj_flat;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adjust u_adjust (
                .digit_in  (scratch_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_out (adj_flat[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            bin_reg     <= '0;
            scratch_reg <= '0;
            bcd_reg     <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            bin_reg     <= bin_next;
            scratch_reg <= scratch_next;
            bcd_reg     <= bcd_next;
            count_reg   <= count_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bin_next     = bin_reg;
        scratch_next = scratch_reg;
        bcd_next     = bcd_reg;
        count_next   = count_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    bin_next     = bus.bin_in;
                    scratch_next = '0;
                    count_next   = CNT_W'(WIDTH);
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                // Adjust happens on the pre-shift digits; the digit MSB drops out the top.
                {scratch_next, bin_next} = {adj_flat, bin_reg} << 1;
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    // Load the result here so it is already visible during DONE.
                    bcd_next   = scratch_next;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_reg == SHIFT);
    assign bus.done    = (state_reg == DONE);
    assign bus.bcd_out = bcd_reg;

endmodule

// File: tb/tb_bcd_conversion_sequencer.sv
// Bench for the BCD converter at WIDTH=8/DIGITS=3 and WIDTH=4/DIGITS=2, checked against decimal arithmetic.
module tb_bcd_conversion_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_conversion_sequencer_if #(.WIDTH(8), .DIGITS(3)) bus8();
  bcd_conversion_sequencer_if #(.WIDTH(4), .DIGITS(2)) bus4();

  bcd_conversion_sequencer #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clock (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  bcd_conversion_sequencer #(.WIDTH(4), .DIGITS(2)) dut4 (
    .clock (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  typedef struct {
    int bin;
    int exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: each BCD digit is simply the matching decimal digit of the value.
  function automatic int model(input int v, input int nd);
    int r = 0;
    int p = 1;
    for (int k = 0; k < nd; k++) begin
      r = r | (((v / p) % 10) << (4 * k));
      p = p * 10;
    end
    return r;
  endfunction

  task automatic conv8(input int v, input int exp, input string tag);
    int t = 0;
    int bc = 0;
    bus8.start  = 1'b1;
    bus8.bin_in = v[7:0];
    step();
    bus8.start = 1'b0;
    while (bus8.done !== 1'b1 && t < 64) begin
      if (bus8.busy === 1'b1) bc++;
      step();
      t++;
    end
    $display("conv8 %s bin=%0d bcd=%h exp=%h", tag, v, bus8.bcd_out, exp[11:0]);
    chk({tag, "_latency"}, t, 8);
    chk({tag, "_busy_cycles"}, bc, 8);
    chk({tag, "_bcd"}, bus8.bcd_out, exp);
    chk({tag, "_busy_at_done"}, bus8.busy, 0);
    step();
    chk({tag, "_done_pulse"}, bus8.done, 0);
    chk({tag, "_bcd_hold"}, bus8.bcd_out, exp);
  endtask

  task automatic conv4(input int v, input int exp, input string tag);
    int t = 0;
    bus4.start  = 1'b1;
    bus4.bin_in = v[3:0];
    step();
    bus4.start = 1'b0;
    while (bus4.done !== 1'b1 && t < 64) begin
      step();
      t++;
    end
    $display("conv4 %s bin=%0d bcd=%h exp=%h", tag, v, bus4.bcd_out, exp[7:0]);
    chk({tag, "_latency"}, t, 4);
    chk({tag, "_bcd"}, bus4.bcd_out, exp);
    step();
    chk({tag, "_done_pulse"}, bus4.done, 0);
  endtask

  initial begin
    vec_t tbl8[5];
    vec_t tbl4[4];
    int   n;
    int   c1;
    int   c2;
    int   v;

    tbl8[0] = '{0,   'h000};
    tbl8[1] = '{255, 'h255};
    tbl8[2] = '{99,  'h099};
    tbl8[3] = '{128, 'h128};
    tbl8[4] = '{64,  'h064};
    tbl4[0] = '{9,  'h09};
    tbl4[1] = '{10, 'h10};
    tbl4[2] = '{15, 'h15};
    tbl4[3] = '{0,  'h00};

    bus8.start = 1'b0; bus8.bin_in = '0;
    bus4.start = 1'b0; bus4.bin_in = '0;
    reset = 1'b1;
    step(); step();
    chk("rst_busy8", bus8.busy, 0);
    chk("rst_done8", bus8.done, 0);
    chk("rst_bcd8", bus8.bcd_out, 0);
    chk("rst_bcd4", bus4.bcd_out, 0);

    // Reset together with start: start must not be captured.
    bus8.start = 1'b1; bus8.bin_in = 8'd77;
    step();
    reset = 1'b0; bus8.start = 1'b0;
    step();
    chk("rst_start_busy", bus8.busy, 0);
    step();

    for (int i = 0; i < 5; i++) conv8(tbl8[i].bin, tbl8[i].exp, $sformatf("tbl8_%0d", i));

    // Start pulse while busy is dropped; only one done follows.
    bus8.start = 1'b1; bus8.bin_in = 8'd200;
    step();
    bus8.start = 1'b0;
    step(); step();
    bus8.start = 1'b1; bus8.bin_in = 8'd17;
    step();
    bus8.start = 1'b0;
    n = 0;
    while (bus8.done !== 1'b1 && n < 64) begin step(); n++; end
    $display("busy_ignore bcd=%h", bus8.bcd_out);
    chk("busy_ignore_bcd", bus8.bcd_out, 'h200);
    n = 0;
    for (int i = 0; i < 15; i++) begin step(); if (bus8.done === 1'b1) n++; end
    chk("busy_ignore_no_done", n, 0);

    // Reset on the 4th SHIFT cycle aborts the conversion.
    bus8.start = 1'b1; bus8.bin_in = 8'd150;
    step();
    bus8.start = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("reset_mid busy=%0d done=%0d bcd=%h", bus8.busy, bus8.done, bus8.bcd_out);
    chk("reset_mid_busy", bus8.busy, 0);
    chk("reset_mid_done", bus8.done, 0);
    chk("reset_mid_bcd", bus8.bcd_out, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin step(); if (bus8.done === 1'b1) n++; end
    chk("reset_mid_no_done", n, 0);

    // Held start: back-to-back conversions, WIDTH+2 apart.
    bus8.start = 1'b1; bus8.bin_in = 8'd42;
    step();
    bus8.bin_in = 8'd7;
    n = 0;
    while (bus8.done !== 1'b1 && n < 64) begin step(); n++; end
    c1 = cyc;
    $display("held_start first bcd=%h", bus8.bcd_out);
    chk("held_first_bcd", bus8.bcd_out, 'h042);
    step();
    n = 0;
    while (bus8.done !== 1'b1 && n < 64) begin step(); n++; end
    c2 = cyc;
    bus8.start = 1'b0;
    $display("held_start second bcd=%h gap=%0d", bus8.bcd_out, c2 - c1);
    chk("held_second_bcd", bus8.bcd_out, 'h007);
    chk("held_gap", c2 - c1, 10);
    step(); step();

    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 255));
      conv8(v, model(v, 3), $sformatf("rnd_%0d", i));
    end

    for (int i = 0; i < 4; i++) conv4(tbl4[i].bin, tbl4[i].exp, $sformatf("tbl4_%0d", i));
    for (int i = 0; i < 16; i++) conv4(i, model(i, 2), $sformatf("sweep4_%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
